// File: rtl/bayer_pkg.sv
// Shared types and luma weights for the Bayer-to-grey converter.
package bayer_pkg;

  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_LUMA  = 2'd1,
    MODE_GREEN = 2'd2,
    MODE_MAX   = 2'd3
  } greyMode_t;

  // Colour filter order of a 2x2 quad, listed TL,TR,BL,BR
  typedef enum logic [1:0] {
    PH_RGGB = 2'd0,
    PH_GRBG = 2'd1,
    PH_GBRG = 2'd2,
    PH_BGGR = 2'd3
  } cfaPhase_t;

  localparam int unsigned COEF_R = 77;
  localparam int unsigned COEF_G = 75;
  localparam int unsigned COEF_B = 29;

endpackage

// File: rtl/bayer_line_buf.sv
// One-line pixel store; the asynchronous read returns the previous line's
// value at an address that is being written in the same cycle.
module bayer_line_buf #(
  parameter  int DATA_W = 12,
  parameter  int LINE_W = 1280,
  localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1
) (
  input  logic              iCLK,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [LINE_W];

  always_ff @(posedge iCLK) begin
    if (wrEn) mem[addr] <= wrData;
  end

  assign rdData = mem[addr];

endmodule

// File: rtl/bayer_grey_conv.sv
// Converts a raw Bayer stream into one grey sample per 2x2 quad through a
// two-stage pipeline (quad capture, then grey computation).
module bayer_grey_conv
  import bayer_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LINE_W = 1280,
  parameter int CNT_W  = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [1:0]        iMODE,
  input  logic [1:0]        iPHASE,
  output logic [DATA_W-1:0] oGrey,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX,
  output logic [CNT_W-1:0]  oY
);

  localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int LUMA_W = DATA_W + 9;

  logic [CNT_W-1:0]  xCnt, yCnt, pixX, pixY;
  logic [DATA_W-1:0] prevLine, prevRd, lastPix;
  logic [DATA_W-1:0] rSel, g1Sel, g2Sel, bSel;
  logic              quadDone;

  logic              s1Valid;
  logic [DATA_W-1:0] s1R, s1B;
  logic [DATA_W:0]   s1Gs;
  greyMode_t         s1Mode;
  logic [CNT_W-1:0]  s1X, s1Y;

  logic [DATA_W+1:0] avgSum;
  logic [LUMA_W-1:0] lumaSum;
  logic [DATA_W-1:0] gHalf, greyNext;

  // A qualified start-of-frame overrides whatever the counters hold
  assign pixX     = iSOF ? '0 : xCnt;
  assign pixY     = iSOF ? '0 : yCnt;
  assign quadDone = iDVAL & pixX[0] & pixY[0];

  bayer_line_buf #(.DATA_W(DATA_W), .LINE_W(LINE_W)) lineBuf (
    .iCLK   (iCLK),
    .wrEn   (iDVAL),
    .addr   (pixX[ADDR_W-1:0]),
    .wrData (iDATA),
    .rdData (prevLine)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      xCnt    <= '0;
      yCnt    <= '0;
      prevRd  <= '0;
      lastPix <= '0;
    end else if (iDVAL) begin
      prevRd  <= prevLine;
      lastPix <= iDATA;
      if (pixX == CNT_W'(LINE_W - 1)) begin
        xCnt <= '0;
        yCnt <= pixY + 1'b1;
      end else begin
        xCnt <= pixX + 1'b1;
        yCnt <= pixY;
      end
    end
  end

  // Quad positions: TL=prevRd, TR=prevLine, BL=lastPix, BR=iDATA
  always_comb begin
    rSel  = iDATA;
    g1Sel = prevLine;
    g2Sel = lastPix;
    bSel  = prevRd;
    case (cfaPhase_t'(iPHASE))
      PH_RGGB: begin rSel = prevRd;   g1Sel = prevLine; g2Sel = lastPix; bSel = iDATA;    end
      PH_GRBG: begin rSel = prevLine; g1Sel = prevRd;   g2Sel = iDATA;   bSel = lastPix;  end
      PH_GBRG: begin rSel = lastPix;  g1Sel = prevRd;   g2Sel = iDATA;   bSel = prevLine; end
      PH_BGGR: begin rSel = iDATA;    g1Sel = prevLine; g2Sel = lastPix; bSel = prevRd;   end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1Valid <= 1'b0;
      s1R     <= '0;
      s1Gs    <= '0;
      s1B     <= '0;
      s1Mode  <= MODE_AVG;
      s1X     <= '0;
      s1Y     <= '0;
    end else begin
      s1Valid <= quadDone;
      if (quadDone) begin
        s1R    <= rSel;
        s1Gs   <= {1'b0, g1Sel} + {1'b0, g2Sel};
        s1B    <= bSel;
        s1Mode <= greyMode_t'(iMODE);
        s1X    <= pixX >> 1;
        s1Y    <= pixY >> 1;
      end
    end
  end

  always_comb begin
    avgSum   = {2'b00, s1R} + {1'b0, s1Gs} + {2'b00, s1B};
    lumaSum  = LUMA_W'(COEF_R) * LUMA_W'(s1R)
             + LUMA_W'(COEF_G) * LUMA_W'(s1Gs)
             + LUMA_W'(COEF_B) * LUMA_W'(s1B);
    gHalf    = DATA_W'(s1Gs >> 1);
    greyNext = '0;
    case (s1Mode)
      MODE_AVG:   greyNext = DATA_W'(avgSum >> 2);
      MODE_LUMA:  greyNext = DATA_W'(lumaSum >> 8);
      MODE_GREEN: greyNext = gHalf;
      MODE_MAX: begin
        greyNext = s1R;
        if (gHalf > greyNext) greyNext = gHalf;
        if (s1B > greyNext)   greyNext = s1B;
      end
      default: greyNext = '0;
    endcase
  end

  // Outputs only move on a completed quad and hold otherwise
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oGrey <= '0;
      oX    <= '0;
      oY    <= '0;
    end else begin
      oDVAL <= s1Valid;
      if (s1Valid) begin
        oGrey <= greyNext;
        oX    <= s1X;
        oY    <= s1Y;
      end
    end
  end

endmodule

// File: tb/tb_bayer_grey_conv.sv
// Drives directed and random Bayer streams into bayer_grey_conv and checks
// every output cycle against a pixel-level reference model.
module tb_bayer_grey_conv;

  localparam int DATA_W = 12;
  localparam int LINE_W = 4;
  localparam int CNT_W  = 11;

  logic              iCLK = 1'b0;
  logic              iRST;
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic              iSOF;
  logic [1:0]        iMODE;
  logic [1:0]        iPHASE;
  logic [DATA_W-1:0] oGrey;
  logic              oDVAL;
  logic [CNT_W-1:0]  oX;
  logic [CNT_W-1:0]  oY;

  bayer_grey_conv #(.DATA_W(DATA_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iDATA  (iDATA),
    .iDVAL  (iDVAL),
    .iSOF   (iSOF),
    .iMODE  (iMODE),
    .iPHASE (iPHASE),
    .oGrey  (oGrey),
    .oDVAL  (oDVAL),
    .oX     (oX),
    .oY     (oY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int grey;
    int qx;
    int qy;
    int due;
  } expQuad_t;

  expQuad_t expQ[$];
  int assertCnt = 0;
  int failCnt   = 0;
  int cyc       = 0;
  int mx = 0, my = 0;
  int col[LINE_W];
  int oldAt[LINE_W];
  int lastG = 0, lastX = 0, lastY = 0;
  int dutLastGrey = 0, dutLastX = 0, dutLastY = 0;

  // Spec-level grey: R sits at quad position 'phase', B at the opposite corner
  function automatic int refGrey(input int mode, input int phase,
                                 input int tl, input int tr, input int bl, input int br);
    int p[4];
    int r, b, gs, m;
    p[0] = tl; p[1] = tr; p[2] = bl; p[3] = br;
    r  = p[phase];
    b  = p[3 - phase];
    gs = tl + tr + bl + br - r - b;
    case (mode)
      0: return (r + gs + b) >> 2;
      1: return (77 * r + 75 * gs + 29 * b) >> 8;
      2: return gs >> 1;
      default: begin
        m = r;
        if ((gs >> 1) > m) m = gs >> 1;
        if (b > m) m = b;
        return m;
      end
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCnt++;
    assert (got === exp)
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    bit dueNow;
    expQuad_t e;
    dueNow = (expQ.size() > 0) && (expQ[0].due == cyc);
    checkEq("oDVAL", {31'd0, oDVAL}, {31'd0, dueNow});
    if (dueNow) begin
      e = expQ.pop_front();
      lastG = e.grey; lastX = e.qx; lastY = e.qy;
    end
    checkEq(dueNow ? "oGrey" : "oGrey_hold", 32'(oGrey), lastG);
    checkEq(dueNow ? "oX" : "oX_hold", 32'(oX), lastX);
    checkEq(dueNow ? "oY" : "oY_hold", 32'(oY), lastY);
    if (oDVAL) begin
      dutLastGrey = oGrey; dutLastX = oX; dutLastY = oY;
    end
  endtask

  task automatic applyStimulus(input logic dval, input logic sof, input logic [11:0] data,
                               input logic [1:0] mode, input logic [1:0] phase);
    int px, py;
    expQuad_t e;
    iDVAL = dval; iSOF = sof; iDATA = data; iMODE = mode; iPHASE = phase;
    if (dval) begin
      px = sof ? 0 : mx;
      py = sof ? 0 : my;
      if ((px % 2 == 1) && (py % 2 == 1)) begin
        e.grey = refGrey(mode, phase, oldAt[px-1], col[px], col[px-1], data);
        e.qx   = px / 2;
        e.qy   = py / 2;
        e.due  = cyc + 2;
        expQ.push_back(e);
      end
      oldAt[px] = col[px];
      col[px]   = data;
      if (px == LINE_W - 1) begin
        mx = 0;
        my = (py + 1) % (1 << CNT_W);
      end else begin
        mx = px + 1;
        my = py;
      end
    end
    @(posedge iCLK);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [1:0] mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 12'h0, mode, 2'd0);
  endtask

  // Two lines of a repeating quad pattern: row0 a,b,a,b then row1 c,d,c,d
  task automatic sendQuadRows(input logic sof, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [11:0] d,
                              input logic [1:0] mode, input logic [1:0] phase);
    for (int i = 0; i < LINE_W; i++)
      applyStimulus(1'b1, sof && (i == 0), (i % 2 == 0) ? a : b, mode, phase);
    for (int i = 0; i < LINE_W; i++)
      applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? c : d, mode, phase);
  endtask

  task automatic resetDut();
    iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0;
    #1;
    checkEq("rst_oDVAL", {31'd0, oDVAL}, 0);
    checkEq("rst_oGrey", 32'(oGrey), 0);
    checkEq("rst_oX", 32'(oX), 0);
    checkEq("rst_oY", 32'(oY), 0);
    expQ.delete();
    mx = 0; my = 0;
    lastG = 0; lastX = 0; lastY = 0;
    @(posedge iCLK);
    cyc++;
    #1;
    checkOutput();
    iRST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LINE_W; i++) begin
      col[i] = 0; oldAt[i] = 0;
    end
    iRST = 1'b1; iDVAL = 1'b0; iSOF = 1'b0; iDATA = '0; iMODE = '0; iPHASE = '0;
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    checkEq("init_oDVAL", {31'd0, oDVAL}, 0);
    checkEq("init_oGrey", 32'(oGrey), 0);
    checkEq("init_oX", 32'(oX), 0);
    checkEq("init_oY", 32'(oY), 0);
    iRST = 1'b0;
    idle(2, 2'd0);

    $display("[TB] flat frame, average mode");
    sendQuadRows(1'b1, 12'h800, 12'h800, 12'h800, 12'h800, 2'd0, 2'd0);
    idle(3, 2'd0);
    checkEq("flat_grey", dutLastGrey, 32'h800);
    checkEq("flat_x", dutLastX, 1);

    $display("[TB] luma extremes");
    sendQuadRows(1'b1, 12'hFFF, 12'h000, 12'h000, 12'h000, 2'd1, 2'd0);
    idle(3, 2'd1);
    checkEq("luma_red", dutLastGrey, 32'h4CF);
    sendQuadRows(1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 2'd1, 2'd0);
    idle(3, 2'd1);
    checkEq("luma_white", dutLastGrey, 32'hFFF);

    $display("[TB] BGGR phase across modes, mode changed right after completion");
    sendQuadRows(1'b1, 12'h100, 12'h200, 12'h300, 12'h400, 2'd2, 2'd3);
    idle(3, 2'd3);
    checkEq("bggr_green", dutLastGrey, 32'h280);
    sendQuadRows(1'b1, 12'h100, 12'h200, 12'h300, 12'h400, 2'd3, 2'd3);
    idle(3, 2'd0);
    checkEq("bggr_max", dutLastGrey, 32'h400);
    sendQuadRows(1'b1, 12'h100, 12'h200, 12'h300, 12'h400, 2'd0, 2'd3);
    idle(3, 2'd1);
    checkEq("bggr_avg", dutLastGrey, 32'h280);

    $display("[TB] random pixels with gaps and changing mode/phase");
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < LINE_W; c++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          applyStimulus(1'b0, 1'($urandom), 12'($urandom), 2'($urandom), 2'($urandom));
        applyStimulus(1'b1, (r == 0) && (c == 0), 12'($urandom), 2'($urandom), 2'($urandom));
      end
    end
    idle(3, 2'd0);

    $display("[TB] start of frame mid-line with a quad in flight");
    sendQuadRows(1'b1, 12'h111, 12'h222, 12'h333, 12'h444, 2'd0, 2'd1);
    for (int i = 0; i < LINE_W; i++) applyStimulus(1'b1, i == 0, 12'(i * 16 + 5), 2'd3, 2'd0);
    applyStimulus(1'b1, 1'b0, 12'h0A0, 2'd3, 2'd0);
    applyStimulus(1'b1, 1'b0, 12'h0B0, 2'd3, 2'd0);
    applyStimulus(1'b1, 1'b1, 12'h050, 2'd0, 2'd0);
    for (int i = 1; i < LINE_W; i++) applyStimulus(1'b1, 1'b0, 12'(i * 32), 2'd0, 2'd0);
    for (int i = 0; i < LINE_W; i++) applyStimulus(1'b1, 1'b0, 12'(i * 64 + 7), 2'd2, 2'd2);
    idle(3, 2'd0);
    checkEq("sof_y", dutLastY, 0);
    checkEq("sof_x", dutLastX, 1);

    $display("[TB] reset mid-stream");
    sendQuadRows(1'b1, 12'h321, 12'h654, 12'h987, 12'hCBA, 2'd0, 2'd0);
    idle(3, 2'd0);
    for (int i = 0; i < LINE_W; i++) applyStimulus(1'b1, i == 0, 12'h0F0, 2'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 12'h00F, 2'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 12'h0FF, 2'd0, 2'd0);
    resetDut();
    idle(2, 2'd0);
    sendQuadRows(1'b0, 12'h400, 12'h200, 12'h600, 12'h100, 2'd3, 2'd0);
    idle(4, 2'd0);
    checkEq("post_rst_x", dutLastX, 1);
    checkEq("post_rst_y", dutLastY, 0);
    checkEq("queue_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/bayer_grey_conv.md
BAYER_GREY_CONV -- requirements
Module: bayer_grey_conv

Interface
REQ-001 SHALL have parameter DATA_W, default 12, the raw and grey pixel width.
REQ-002 SHALL have parameter LINE_W, default 1280, the input pixels per line.
REQ-003 SHALL have parameter CNT_W, default 11, the width of the coordinate counters.
REQ-004 iCLK  in  1  sole clock; all logic on its rising edge.
REQ-005 iRST  in  1  reset, asynchronous, active-high.
REQ-006 iDATA  in  DATA_W  raw Bayer pixel.
REQ-007 iDVAL  in  1  iDATA valid this cycle.
REQ-008 iSOF  in  1  start of frame; qualified by iDVAL, marks pixel (0,0).
REQ-009 iMODE  in  2  grey mode: 0 avg, 1 luma, 2 green, 3 max.
REQ-010 iPHASE  in  2  CFA order of a 2x2 quad: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR (TL,TR,BL,BR).
REQ-011 oGrey  out  DATA_W  grey value, one per 2x2 quad.
REQ-012 oDVAL  out  1  oGrey/oX/oY valid, one-cycle pulse per quad.
REQ-013 oX, oY  out  CNT_W each  quad coordinates: input x>>1 and y>>1.

Function
REQ-014 Internal x/y counters SHALL advance only on iDVAL cycles; they hold when iDVAL is low.
REQ-015 x SHALL wrap from LINE_W-1 to 0 and increment y; y SHALL wrap from 2^CNT_W-1 to 0.
REQ-016 iSOF&iDVAL SHALL force that pixel to x=0,y=0 regardless of counter state; iSOF without iDVAL SHALL be ignored.
REQ-017 Every valid pixel SHALL be written to a one-line buffer at address x; a read at the same address in the same cycle SHALL return the previous line's value.
REQ-018 A quad SHALL complete on the iDVAL pixel with x odd and y odd: TL=prev(x-1), TR=prev(x), BL=cur(x-1), BR=cur(x); no other pixel SHALL produce output.
REQ-019 iPHASE SHALL map the quad positions to R, G1, G2 and B; Gs=G1+G2 is DATA_W+1 bits wide.
REQ-020 Mode 0 SHALL output (R+Gs+B)>>2.
REQ-021 Mode 1 SHALL output (77R+75Gs+29B)>>8; the intermediate width SHALL hold 256*(2^DATA_W-1) without overflow.
REQ-022 Mode 2 SHALL output Gs>>1.
REQ-023 Mode 3 SHALL output max(R, Gs>>1, B).
REQ-024 All results SHALL truncate (no rounding) and always fit DATA_W bits.
REQ-025 iMODE and iPHASE SHALL be sampled on the quad-completing cycle; later changes SHALL NOT affect a quad already in flight.
REQ-026 The pipeline SHALL have 2 stages: stage 1 registers R/Gs/B, mode and coordinates; stage 2 registers oGrey, oX, oY and oDVAL. oDVAL SHALL rise exactly 2 cycles after the completing iDVAL.
REQ-027 The pipeline SHALL NOT stall: every completed quad SHALL produce exactly one oDVAL pulse, including back-to-back quads.
REQ-028 A quad in flight at iSOF SHALL still emit with its original coordinates.
REQ-029 Between oDVAL pulses, oGrey/oX/oY SHALL hold their last values.

Reset
REQ-030 iRST high SHALL immediately clear oGrey, oDVAL, oX, oY, the counters and the pipeline registers to 0.
REQ-031 Line-buffer contents SHALL NOT be reset.
REQ-032 After reset, the first valid pixel SHALL be (0,0) even without iSOF.

Structure
REQ-033 Package bayer_pkg SHALL hold the mode and phase enums and the coefficients 77, 75 and 29.
REQ-034 The line buffer SHALL be the sub-module bayer_line_buf (DATA_W, LINE_W) with a read-old-on-write port; all other logic stays in bayer_grey_conv.

Verification (DATA_W=12, LINE_W=4)
REQ-035 Reset: assert iRST mid-stream -> oDVAL=0, oGrey=0, oX=oY=0 in the same cycle; first post-reset pixel is treated as (0,0).
REQ-036 Flat frame of 0x800, mode 0, phase 0 -> two pulses oGrey=0x800, (oX,oY)=(0,0) then (1,0), each 2 cycles after pixels (1,1) and (3,1); no output on row 0.
REQ-037 Mode 1, phase 0, R=0xFFF, G=B=0 -> oGrey=0x4CF; all pixels 0xFFF -> oGrey=0xFFF with no overflow.
REQ-038 Phase 3, quad TL=0x100, TR=0x200, BL=0x300, BR=0x400: mode 2 -> 0x280; mode 3 -> 0x400; mode 0 -> 0x280.
REQ-039 Random iDVAL gaps give the same outputs as the gapless case; iMODE toggled the cycle after the completing pixel does not alter that quad's result.
REQ-040 iSOF&iDVAL at x=2 of row 1 -> counters restart at (0,0) and the next quad emits at oY=0; a quad in flight still emits with its old coordinates.
